// File: rtl/addr4u_seq_ctrl.sv
// ---------------------------------------------------------------------------
// addr4u_seq_ctrl
//
// Purpose:
//   Sequences a (4*NIBBLES)-bit unsigned addition through one external 4-bit
//   adder (add_a/add_b out, add_o back in), one nibble per pass.  A carry into
//   nibble k >= 1 is resolved with a second "increment" pass through the same
//   adder.  Two requesters share the block through a round-robin arbiter.
//
// Optional feature (macro ADDR4U_SEQ_DMR_EN):
//   Defined   -> every SUM/INC pass is repeated once in a CHK cycle.  A
//                differing second result sets a sticky error flag reported on
//                o_rsp_err.  The first-pass result is always the one used.
//   Undefined -> no CHK state, o_rsp_err is tied low.
//
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_reqN_valid / o_reqN_ready   requester N handshake (N = 0, 1)
//   i_reqN_a, i_reqN_b            requester N operands (W bits)
//   o_rsp_valid / i_rsp_ready     result handshake
//   o_rsp_id                      requester that owns the result
//   o_rsp_sum                     W+1 bit sum, MSB = final carry
//   o_rsp_err                     adder mismatch seen (checked builds only)
//   o_add_a, o_add_b              external adder operands
//   i_add_o                       external adder result (same cycle)
// ---------------------------------------------------------------------------
module addr4u_seq_ctrl #(
    parameter  int NIBBLES = 4,
    localparam int W       = 4 * NIBBLES
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_req0_valid,
    output logic         o_req0_ready,
    input  logic [W-1:0] i_req0_a,
    input  logic [W-1:0] i_req0_b,
    input  logic         i_req1_valid,
    output logic         o_req1_ready,
    input  logic [W-1:0] i_req1_a,
    input  logic [W-1:0] i_req1_b,
    output logic         o_rsp_valid,
    input  logic         i_rsp_ready,
    output logic         o_rsp_id,
    output logic [W:0]   o_rsp_sum,
    output logic         o_rsp_err,
    output logic [3:0]   o_add_a,
    output logic [3:0]   o_add_b,
    input  logic [4:0]   i_add_o
);

    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

`ifdef ADDR4U_SEQ_DMR_EN
    typedef enum logic [2:0] {S_IDLE, S_SUM, S_INC, S_DONE, S_CHK} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SUM, S_INC, S_DONE} state_t;
`endif

    state_t         r_state;
    state_t         w_state_next;
    logic           r_ptr;
    logic           r_id;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [KW-1:0]  r_k;
    logic           r_carry;
    logic [4:0]     r_tmp;
    logic [W:0]     r_sum;

    logic           w_grant0;
    logic           w_grant1;
    logic           w_last;
    logic [3:0]     w_a_nib;
    logic [3:0]     w_b_nib;
    // w_commit: the current nibble result is final this cycle
    logic           w_commit;
    logic [3:0]     w_fin_nib;
    logic           w_fin_carry;

`ifdef ADDR4U_SEQ_DMR_EN
    logic [4:0]     r_res;       // first-pass result of the pass being checked
    logic           r_from_inc;  // CHK is re-running an INC pass
    logic           r_err;
`endif

    assign w_grant0 = i_req0_valid & (~i_req1_valid | ~r_ptr);
    assign w_grant1 = i_req1_valid & (~i_req0_valid |  r_ptr);
    assign w_last   = (r_k == KW'(NIBBLES - 1));
    assign w_a_nib  = r_a[{r_k, 2'b00} +: 4];
    assign w_b_nib  = r_b[{r_k, 2'b00} +: 4];

    assign o_rsp_valid = (r_state == S_DONE);
    assign o_rsp_id    = r_id;
    assign o_rsp_sum   = r_sum;
`ifdef ADDR4U_SEQ_DMR_EN
    assign o_rsp_err   = (r_state == S_DONE) & r_err;
`else
    assign o_rsp_err   = 1'b0;
`endif

    // Next state, adder drive, readies and nibble commit
    always_comb begin
        w_state_next = r_state;
        o_add_a      = 4'd0;
        o_add_b      = 4'd0;
        o_req0_ready = 1'b0;
        o_req1_ready = 1'b0;
        w_commit     = 1'b0;
        w_fin_nib    = 4'd0;
        w_fin_carry  = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_req0_ready = w_grant0;
                o_req1_ready = w_grant1;
                if (w_grant0 | w_grant1)
                    w_state_next = S_SUM;
            end
            S_SUM: begin
                o_add_a = w_a_nib;
                o_add_b = w_b_nib;
`ifdef ADDR4U_SEQ_DMR_EN
                w_state_next = S_CHK;
`else
                if (r_carry) begin
                    w_state_next = S_INC;
                end else begin
                    w_commit     = 1'b1;
                    w_fin_nib    = i_add_o[3:0];
                    w_fin_carry  = i_add_o[4];
                    w_state_next = w_last ? S_DONE : S_SUM;
                end
`endif
            end
            S_INC: begin
                o_add_a = r_tmp[3:0];
                o_add_b = 4'b0001;
`ifdef ADDR4U_SEQ_DMR_EN
                w_state_next = S_CHK;
`else
                w_commit     = 1'b1;
                w_fin_nib    = i_add_o[3:0];
                w_fin_carry  = r_tmp[4] | i_add_o[4];
                w_state_next = w_last ? S_DONE : S_SUM;
`endif
            end
`ifdef ADDR4U_SEQ_DMR_EN
            S_CHK: begin
                o_add_a = r_from_inc ? r_tmp[3:0] : w_a_nib;
                o_add_b = r_from_inc ? 4'b0001    : w_b_nib;
                if (!r_from_inc && r_carry) begin
                    w_state_next = S_INC;
                end else begin
                    w_commit     = 1'b1;
                    w_fin_nib    = r_res[3:0];
                    w_fin_carry  = r_from_inc ? (r_tmp[4] | r_res[4]) : r_res[4];
                    w_state_next = w_last ? S_DONE : S_SUM;
                end
            end
`endif
            S_DONE: begin
                if (i_rsp_ready)
                    w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
        if (i_rst) begin
            o_req0_ready = 1'b0;
            o_req1_ready = 1'b0;
            o_add_a      = 4'd0;
            o_add_b      = 4'd0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_ptr   <= 1'b0;
            r_id    <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_k     <= '0;
            r_carry <= 1'b0;
            r_tmp   <= '0;
            r_sum   <= '0;
`ifdef ADDR4U_SEQ_DMR_EN
            r_res      <= '0;
            r_from_inc <= 1'b0;
            r_err      <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            if (r_state == S_IDLE && (w_grant0 | w_grant1)) begin
                r_a     <= w_grant0 ? i_req0_a : i_req1_a;
                r_b     <= w_grant0 ? i_req0_b : i_req1_b;
                r_id    <= w_grant1;
                r_ptr   <= w_grant0;   // pointer moves to the other requester
                r_k     <= '0;
                r_carry <= 1'b0;
                r_sum   <= '0;
`ifdef ADDR4U_SEQ_DMR_EN
                r_err   <= 1'b0;
`endif
            end
            if (r_state == S_SUM)
                r_tmp <= i_add_o;
`ifdef ADDR4U_SEQ_DMR_EN
            if (r_state == S_SUM || r_state == S_INC) begin
                r_res      <= i_add_o;
                r_from_inc <= (r_state == S_INC);
            end
            if (r_state == S_CHK && i_add_o != r_res)
                r_err <= 1'b1;
`endif
            if (w_commit) begin
                r_sum[{r_k, 2'b00} +: 4] <= w_fin_nib;
                r_carry                  <= w_fin_carry;
                if (w_last)
                    r_sum[W] <= w_fin_carry;
                else
                    r_k <= r_k + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_addr4u_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_addr4u_seq_ctrl
//
// Directed bench for addr4u_seq_ctrl (NIBBLES = 4).  The external 4-bit adder
// is modelled here; it can flip add_o[2] in one chosen cycle to inject an
// adder fault.  Honours ADDR4U_SEQ_DMR_EN for the checked build.
// ---------------------------------------------------------------------------
module tb_addr4u_seq_ctrl;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;
`ifdef ADDR4U_SEQ_DMR_EN
    localparam int PF  = 2;
`else
    localparam int PF  = 1;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         v0, v1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         r0, r1;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [W:0]   rsp_sum;
    logic [3:0]   add_a, add_b;
    logic [4:0]   add_o;
    logic         flip;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    always_comb add_o = ({1'b0, add_a} + {1'b0, add_b}) ^ (flip ? 5'b00100 : 5'b00000);

    addr4u_seq_ctrl #(.NIBBLES(NIB)) u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req0_valid (v0),
        .o_req0_ready (r0),
        .i_req0_a     (a0),
        .i_req0_b     (b0),
        .i_req1_valid (v1),
        .o_req1_ready (r1),
        .i_req1_a     (a1),
        .i_req1_b     (b1),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_id     (rsp_id),
        .o_rsp_sum    (rsp_sum),
        .o_rsp_err    (rsp_err),
        .o_add_a      (add_a),
        .o_add_b      (add_b),
        .i_add_o      (add_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full transaction from requester `id`; exp_p is the pass count of
    // the unchecked build.  Called just after a posedge (+1).
    task automatic run_txn(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W:0] exp_sum, input int exp_p, input int hold,
                           input int inc_chk, input int fault_n, input logic exp_err);
        int n;
        if (id) begin v1 = 1'b1; a1 = a; b1 = b; end
        else    begin v0 = 1'b1; a0 = a; b0 = b; end
        #1;
        n = 0;
        while ((id ? r1 : r0) !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check_eq("grant", id ? r1 : r0, 1);
        check_eq("loser_rdy", id ? r0 : r1, 0);
        @(posedge clk); #1;
        if (id) v1 = 1'b0; else v0 = 1'b0;
        n = 1;
        while (rsp_valid !== 1'b1 && n < 100) begin
            flip = (n == fault_n);
            if (inc_chk != 0 && PF == 1 && (n == 3 || n == 5 || n == 7)) begin
                check_eq("inc_add_b", add_b, 4'b0001);
                check_eq("inc_add_a", add_a, 4'hF);
            end
            @(posedge clk); #1; n++;
        end
        flip = 1'b0;
        check_eq("latency", n, exp_p * PF + 1);
        check_eq("sum", rsp_sum, exp_sum);
        check_eq("id", rsp_id, id);
        check_eq("err", rsp_err, exp_err);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check_eq("hold_valid", rsp_valid, 1);
            check_eq("hold_sum", rsp_sum, exp_sum);
            check_eq("hold_id", rsp_id, id);
            check_eq("hold_rdy", {r0, r1}, 0);
        end
        rsp_ready = 1'b1;
        #1;
        check_eq("hs_rdy", {r0, r1}, 0);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check_eq("post_valid", rsp_valid, 0);
        $display("txn id=%0d a=%h b=%h sum=%h passes=%0d err=%0d", id, a, b, exp_sum, n - 1, exp_err);
    endtask

    initial begin
        int n;
        int n_inc;
        logic g;
        rst = 1'b1; flip = 1'b0; rsp_ready = 1'b0;
        v0 = 1'b1; a0 = 16'h1234; b0 = 16'h4321;
        v1 = 1'b1; a1 = 16'hFFFF; b1 = 16'h0001;

        // Reset state, readies forced low with both valids high
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_rdy", {r0, r1}, 0);
        check_eq("rst_valid", rsp_valid, 0);
        check_eq("rst_sum", rsp_sum, 0);
        check_eq("rst_id", rsp_id, 0);
        check_eq("rst_err", rsp_err, 0);
        check_eq("rst_add", {add_a, add_b}, 0);
        rst = 1'b0;

        // Round robin with both requesters held valid
        for (int i = 0; i < 4; i++) begin
            #1;
            n = 0;
            while (!(r0 === 1'b1 || r1 === 1'b1) && n < 20) begin
                @(posedge clk); #1; n++;
            end
            g = r1;
            check_eq("rr_order", g, (i % 2));
            check_eq("rr_loser", g ? r0 : r1, 0);
            @(posedge clk); #1;
            n = 0;
            while (rsp_valid !== 1'b1 && n < 100) begin
                @(posedge clk); #1; n++;
            end
            check_eq("rr_sum", rsp_sum, (i % 2) ? 17'h10000 : 17'h05555);
            check_eq("rr_id", rsp_id, (i % 2));
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
            $display("txn rr%0d id=%0d sum=%h", i, rsp_id, rsp_sum);
        end
        v0 = 1'b0; v1 = 1'b0;
        @(posedge clk); #1;

        // Plain sum, then full carry ripple through INC passes
        run_txn(1'b0, 16'h1234, 16'h4321, 17'h05555, 4, 0, 0, 0, 1'b0);
        run_txn(1'b1, 16'hFFFF, 16'h0001, 17'h10000, 7, 0, 1, 0, 1'b0);

        // Back-pressure in DONE while requester 1 waits, then immediate accept
        v1 = 1'b1; a1 = 16'h0008; b1 = 16'h0008;
        run_txn(1'b0, 16'h0F0F, 16'h0101, 17'h01010, 6, 5, 0, 0, 1'b0);
        run_txn(1'b1, 16'h0008, 16'h0008, 17'h00010, 5, 0, 0, 0, 1'b0);

        // Reset pulse during the INC of nibble 1
        n_inc = (PF == 2) ? 5 : 3;
        v1 = 1'b1; a1 = 16'hFFFF; b1 = 16'h0001;
        #1;
        n = 0;
        while (r1 !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check_eq("mr_grant", r1, 1);
        @(posedge clk); #1;
        v1 = 1'b0;
        n = 1;
        while (n < n_inc) begin
            @(posedge clk); #1; n++;
        end
        check_eq("mr_inc_add_b", add_b, 4'b0001);
        rst = 1'b1; v0 = 1'b1; a0 = 16'h0008; b0 = 16'h0008;
        #1;
        check_eq("mr_rst_rdy", r0, 0);
        v0 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("mr_valid", rsp_valid, 0);
        check_eq("mr_sum", rsp_sum, 0);
        check_eq("mr_id", rsp_id, 0);
        check_eq("mr_err", rsp_err, 0);
        check_eq("mr_add", {add_a, add_b}, 0);
        check_eq("mr_rdy", {r0, r1}, 0);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check_eq("mr_no_rsp", rsp_valid, 0);
        end
        run_txn(1'b0, 16'h0008, 16'h0008, 17'h00010, 5, 0, 0, 0, 1'b0);

`ifdef ADDR4U_SEQ_DMR_EN
        // Clean checked run, then a fault in the CHK cycle of nibble 1
        run_txn(1'b0, 16'h1234, 16'h4321, 17'h05555, 4, 0, 0, 0, 1'b0);
        run_txn(1'b0, 16'h1234, 16'h4321, 17'h05555, 4, 0, 0, 4, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/addr4u_seq_ctrl.md
# addr4u_seq_ctrl

Sequencer and arbiter that shares one 4-bit unsigned adder core (A[3:0], B[3:0] in, O[4:0] out, no carry-in) between two requesters. It computes (4·NIBBLES)-bit sums one nibble per pass. Carry propagation uses an extra increment pass through the same adder. The adder is not instantiated internally: it is driven through the add_* ports, so any area- or resilience-optimised adder variant can be plugged in beside this block.

## Interface

- NIBBLES, 4, operand width W = 4·NIBBLES; legal range 1..8
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has operands
- req0_ready  out  1  requester 0 operands accepted this cycle
- req0_a, req0_b  in  W  requester 0 operands
- req1_valid / req1_ready / req1_a / req1_b: same meaning for requester 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_id  out  1  index of the requester that owns the result
- rsp_sum  out  W+1  unsigned sum, MSB = final carry
- rsp_err  out  1  adder mismatch detected (DMR builds only)
- add_a, add_b  out  4  adder operand inputs
- add_o  in  5  adder combinational result, sampled at the end of the same cycle

## Operation

- FSM states: IDLE, SUM, INC, DONE (plus CHK, see Configuration).
- **IDLE**
  - add_a = add_b = 0.
  - Round-robin grant:
    - Pointer resets to 0.
    - If both requesters are valid, the pointer's requester wins.
    - If one is valid, that requester wins.
    - After any grant the pointer moves to the other requester.
  - reqN_ready = 1 only for the granted requester. It is combinational from state and valids.
  - On handshake: latch operands and rsp_id, set k = 0 and carry = 0, clear err, go to SUM.
- **SUM k**
  - add_a = a[4k+3:4k], add_b = b[4k+3:4k]; capture add_o into tmp.
  - If carry = 0: nibble k = tmp[3:0], carry = tmp[4], advance.
  - If carry = 1: go to INC.
- **INC**
  - add_a = tmp[3:0], add_b = 4'b0001.
  - nibble k = add_o[3:0], carry = tmp[4] | add_o[4]. The two carries cannot both be 1.
  - Advance.
- **Advance**
  - If k = NIBBLES−1: rsp_sum[W] = carry, go to DONE.
  - Otherwise: k = k+1, go to SUM.
- **DONE**
  - rsp_valid = 1; rsp_sum, rsp_id and rsp_err are held stable.
  - On rsp_ready: go to IDLE.
  - No request is accepted in the DONE→IDLE handshake cycle, which gives one bubble.
- Requesters must hold valid and operands stable until ready. Dropping valid before ready is legal and simply withdraws the request.
- Nibble 0 never takes INC, because the initial carry is 0.

## Timing

- Handshake in cycle T. The first SUM is in cycle T+1. rsp_valid rises in cycle T+1+P.
  - P = number of adder passes.
  - P = NIBBLES + (number of nibbles k ≥ 1 entering SUM with carry = 1).
  - NIBBLES ≤ P ≤ 2·NIBBLES−1.
- Back-to-back transactions: the next accept is no earlier than 1 cycle after the rsp handshake.
- Reset values (registered and combinational):
  - rsp_valid = 0, rsp_sum = 0, rsp_id = 0, rsp_err = 0
  - add_a = add_b = 0
  - req0_ready = req1_ready = 0, forced low while rst = 1
  - state = IDLE, pointer = 0
- rst asserted mid-transaction (any state, including DONE): the transaction is discarded and no response is produced. The block behaves as after a power-on reset from the next cycle.
- add_o is ignored outside SUM, INC and CHK.

## Configuration

- Macro: ADDR4U_SEQ_DMR_EN.
- Defined:
  - Every SUM and INC pass is followed by a CHK cycle that re-drives identical add_a/add_b.
  - The CHK add_o is compared with the first result. A mismatch sets a sticky err for the transaction, and rsp_err = err in DONE.
  - The first-pass result is always used.
  - P doubles.
- Undefined:
  - No CHK state; rsp_err is tied to 0.

## Test plan

- NIBBLES = 4, req0 a = 0x1234, b = 0x4321 → rsp_sum = 0x05555, rsp_id = 0, P = 4, rsp_valid at T+5.
- req1 a = 0xFFFF, b = 0x0001 → rsp_sum = 0x10000, rsp_id = 1, P = 7 (SUM+INC for nibbles 1..3), rsp_valid at T+8; add_b = 4'b0001 in each INC cycle.
- Both requesters valid and held after reset, each transaction completed → grant order 0, 1, 0, 1; the ready of the losing requester stays 0 while it is not granted.
- rsp_ready held low 5 cycles in DONE → rsp_valid = 1 with rsp_sum/rsp_id stable throughout, both readies 0; release → IDLE, next accept ≥ 1 cycle later.
- rst pulsed for 1 cycle during INC of a = 0xFFFF, b = 0x0001 → all outputs 0 next cycle, no rsp_valid; a following a = 0x0008, b = 0x0008 returns 0x00010.
- ADDR4U_SEQ_DMR_EN defined, bench adder flips add_o[2] in the CHK cycle of nibble 1 → rsp_err = 1 and rsp_sum still correct. An unfaulted run gives rsp_err = 0 and P = 8 for 0x1234 + 0x4321.
